// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings the SoC PLL out of reset, qualifies lock, then
// releases peripheral reset followed by core reset. Runs from the board
// reference clock, so it keeps working when the PLL drops lock.
// Optional retry limit: define RSTSEQ_RETRY_LIMIT_EN to add the FAIL state.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// PLL_RST     | pll_rst held high for PLL_RST_CYCLES, both SoC resets asserted
// WAIT_LOCK   | pll_rst low, waiting for synchronized lock or timeout
// STABLE      | lock seen, counting consecutive locked cycles
// PERIPH_UP   | periph_rst_n released, core still held for CORE_DELAY_CYCLES
// RUN         | everything released, seq_done high
// FAIL        | retry limit exhausted, PLL held in reset until rst_n
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CORE_DELAY_CYCLES   = 64,
  parameter int MAX_RETRIES         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic       seq_done,
  output logic [7:0] lock_loss_cnt,
  output logic       fail
);

  // One counter serves every timed state, so size it for the longest wait.
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ? LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST    = CNT_W'(CORE_DELAY_CYCLES - 1);

  if (SYNC_STAGES < 2 || PLL_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      LOCK_STABLE_CYCLES < 1 || CORE_DELAY_CYCLES < 1 || MAX_RETRIES < 1) begin : g_param_check
    $error("pll_reset_sequencer: parameter below its minimum");
  end

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_PERIPH_UP = 3'd3,
`ifdef RSTSEQ_RETRY_LIMIT_EN
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
`else
    S_RUN       = 3'd4
`endif
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             locked_s;
  logic             lock_loss;
  logic             timeout;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // pll_locked comes from the PLL's own analog domain; bring it onto clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

`ifdef RSTSEQ_RETRY_LIMIT_EN
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  logic [RETRY_W-1:0] retry_q;
  logic               retry_exhausted;
  assign retry_exhausted = (retry_q == RETRY_W'(MAX_RETRIES - 1));
`endif

  // Next-state decode. A lock loss after qualification has priority so it is
  // counted even when a software request arrives on the same cycle.
  always_comb begin
    state_nxt = state_q;
    lock_loss = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (sw_reset_req) state_nxt = S_PLL_RST;
        else if (locked_s) state_nxt = S_STABLE;
        else if (cnt_q == TIMEOUT_LAST) begin
          timeout   = 1'b1;
`ifdef RSTSEQ_RETRY_LIMIT_EN
          state_nxt = retry_exhausted ? S_FAIL : S_PLL_RST;
`else
          state_nxt = S_PLL_RST;
`endif
        end
      end
      S_STABLE: begin
        if (sw_reset_req) state_nxt = S_PLL_RST;
        else if (!locked_s) state_nxt = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_nxt = S_PERIPH_UP;
      end
      S_PERIPH_UP: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
          state_nxt = S_PLL_RST;
        end else if (sw_reset_req) state_nxt = S_PLL_RST;
        else if (cnt_q == CORE_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!locked_s) begin
          lock_loss = 1'b1;
          state_nxt = S_PLL_RST;
        end else if (sw_reset_req) state_nxt = S_PLL_RST;
      end
`ifdef RSTSEQ_RETRY_LIMIT_EN
      S_FAIL: state_nxt = S_FAIL;
`endif
      default: state_nxt = S_PLL_RST;
    endcase
  end

  // State register and shared cycle counter; the counter restarts on every
  // state change and only runs in states that time something.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_nxt != state_q)  cnt_q <= '0;
      else if (state_q != S_RUN) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef RSTSEQ_RETRY_LIMIT_EN
  // Consecutive timeouts; cleared once lock has been qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else if (state_q == S_STABLE && state_nxt == S_PERIPH_UP) retry_q <= '0;
    else if (timeout && state_nxt == S_PLL_RST) retry_q <= retry_q + RETRY_W'(1);
  end

  // Fail flag follows the FAIL state with the same edge as the other outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fail <= 1'b0;
    else        fail <= (state_nxt == S_FAIL);
  end
`else
  assign fail = 1'b0;
`endif

  // Outputs decoded from next state so they change on the same edge as the
  // state; both SoC resets assert together and release strictly in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst      <= 1'b1;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      seq_done     <= 1'b0;
    end else begin
      pll_rst      <= (state_nxt == S_PLL_RST)
`ifdef RSTSEQ_RETRY_LIMIT_EN
                      || (state_nxt == S_FAIL)
`endif
                      ;
      periph_rst_n <= (state_nxt == S_PERIPH_UP) || (state_nxt == S_RUN);
      core_rst_n   <= (state_nxt == S_RUN);
      seq_done     <= (state_nxt == S_RUN);
    end
  end

  // Saturating count of lock losses seen after lock was qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_loss_cnt <= 8'd0;
    else if (lock_loss && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Edge k is the k-th rising clk edge after rst_n release; inputs change and
// outputs are sampled 1 ns after an edge.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_rst;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       seq_done;
  logic [7:0] lock_loss_cnt;
  logic       fail;

  int total = 0;
  int bad   = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES(8),
    .CORE_DELAY_CYCLES(4),
    .MAX_RETRIES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .pll_rst(pll_rst),
    .periph_rst_n(periph_rst_n),
    .core_rst_n(core_rst_n),
    .seq_done(seq_done),
    .lock_loss_cnt(lock_loss_cnt),
    .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges, then release so the next edge is edge 1.
  task automatic rel();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    sw_reset_req = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_run();
    int n = 0;
    while (seq_done !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    chk("wait_run", seq_done, 1);
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    step(2);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_periph", periph_rst_n, 0);
    chk("rst_core", core_rst_n, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_loss_cnt", lock_loss_cnt, 0);
    chk("rst_fail", fail, 0);

    // Normal bring-up: lock first sampled at edge 10
    rel();
    step(3);                                     // edge 3
    chk("up_pll_rst_e3", pll_rst, 1);
    step(1);                                     // edge 4
    chk("up_pll_rst_e4", pll_rst, 0);
    step(5);                                     // edge 9
    pll_locked = 1'b1;
    step(10);                                    // edge 19
    chk("up_periph_e19", periph_rst_n, 0);
    step(1);                                     // edge 20
    chk("up_periph_e20", periph_rst_n, 1);
    chk("up_core_e20", core_rst_n, 0);
    step(3);                                     // edge 23
    chk("up_core_e23", core_rst_n, 0);
    step(1);                                     // edge 24
    chk("up_core_e24", core_rst_n, 1);
    chk("up_done_e24", seq_done, 1);
    chk("up_pll_rst_e24", pll_rst, 0);

    // Lock loss in RUN: drop after edge 26, resets on the third edge
    step(2);                                     // edge 26
    pll_locked = 1'b0;
    step(2);                                     // edge 28
    chk("loss_done_e28", seq_done, 1);
    chk("loss_periph_e28", periph_rst_n, 1);
    step(1);                                     // edge 29
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_periph", periph_rst_n, 0);
    chk("loss_core", core_rst_n, 0);
    chk("loss_done", seq_done, 0);
    chk("loss_cnt_1", lock_loss_cnt, 1);
    pll_locked = 1'b1;
    step(3);                                     // edge 32
    chk("reup_pll_rst_e32", pll_rst, 1);
    step(1);                                     // edge 33
    chk("reup_pll_rst_e33", pll_rst, 0);
    step(8);                                     // edge 41
    chk("reup_periph_e41", periph_rst_n, 0);
    step(1);                                     // edge 42
    chk("reup_periph_e42", periph_rst_n, 1);
    step(4);                                     // edge 46
    chk("reup_core_e46", core_rst_n, 1);
    chk("reup_done_e46", seq_done, 1);

    // Software request in RUN
    sw_reset_req = 1'b1;
    step(1);                                     // edge 47
    sw_reset_req = 1'b0;
    chk("sw_pll_rst", pll_rst, 1);
    chk("sw_periph", periph_rst_n, 0);
    chk("sw_core", core_rst_n, 0);
    chk("sw_done", seq_done, 0);
    chk("sw_loss_cnt", lock_loss_cnt, 1);
    // Software request inside PLL_RST must not extend it
    step(1);                                     // edge 48
    sw_reset_req = 1'b1;
    step(1);                                     // edge 49
    sw_reset_req = 1'b0;
    step(1);                                     // edge 50
    chk("swp_pll_rst_e50", pll_rst, 1);
    step(1);                                     // edge 51
    chk("swp_pll_rst_e51", pll_rst, 0);
    step(8);                                     // edge 59
    chk("swp_periph_e59", periph_rst_n, 0);
    step(1);                                     // edge 60
    chk("swp_periph_e60", periph_rst_n, 1);
    step(4);                                     // edge 64
    chk("swp_done_e64", seq_done, 1);

    // Simultaneous software request and lock loss: loss is counted
    pll_locked = 1'b0;
    step(2);                                     // edge 66
    sw_reset_req = 1'b1;
    step(1);                                     // edge 67
    sw_reset_req = 1'b0;
    chk("both_pll_rst", pll_rst, 1);
    chk("both_loss_cnt", lock_loss_cnt, 2);

    // Asynchronous reset clears everything without a clock edge
    rst_n = 1'b0;
    #1;
    chk("async_loss_cnt", lock_loss_cnt, 0);
    chk("async_pll_rst", pll_rst, 1);

    // Glitchy lock: samples high at 10-14, low at 15, high from 16
    rel();
    step(9);                                     // edge 9
    pll_locked = 1'b1;
    step(5);                                     // edge 14
    pll_locked = 1'b0;
    step(1);                                     // edge 15
    pll_locked = 1'b1;
    for (int e = 16; e <= 25; e++) begin
      step(1);
      chk("glitch_pll_rst", pll_rst, 0);
      chk("glitch_periph", periph_rst_n, 0);
    end
    step(1);                                     // edge 26
    chk("glitch_periph_e26", periph_rst_n, 1);

    // Timeout retries with lock held low
    rel();
    step(35);                                    // edge 35
    chk("to_pll_rst_e35", pll_rst, 0);
    step(1);                                     // edge 36
    chk("to_pll_rst_e36", pll_rst, 1);
    step(3);                                     // edge 39
    chk("to_pll_rst_e39", pll_rst, 1);
    step(1);                                     // edge 40
    chk("to_pll_rst_e40", pll_rst, 0);
    step(31);                                    // edge 71
    chk("to_pll_rst_e71", pll_rst, 0);
    step(1);                                     // edge 72
    chk("to_pll_rst_e72", pll_rst, 1);
    step(4);                                     // edge 76
    chk("to_pll_rst_e76", pll_rst, 0);
    chk("to_periph_e76", periph_rst_n, 0);
    step(32);                                    // edge 108, third timeout
    chk("to_pll_rst_e108", pll_rst, 1);
`ifdef RSTSEQ_RETRY_LIMIT_EN
    chk("to_fail_e108", fail, 1);
    pll_locked = 1'b1;
    step(30);
    chk("fail_pll_rst", pll_rst, 1);
    chk("fail_periph", periph_rst_n, 0);
    chk("fail_hold", fail, 1);
    rst_n = 1'b0;
    #1;
    chk("fail_clear", fail, 0);
`else
    chk("to_fail_e108", fail, 0);
    step(4);                                     // edge 112
    chk("to_pll_rst_e112", pll_rst, 0);
    step(32);                                    // edge 144, fourth timeout
    chk("to_pll_rst_e144", pll_rst, 1);
    chk("to_fail_e144", fail, 0);
`endif

    // Repeated lock losses saturate the counter
    rel();
    step(9);
    pll_locked = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      wait_run();
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      if (i == 254) chk("sat_cnt_254", lock_loss_cnt, 254);
    end
    wait_run();
    chk("sat_cnt_255", lock_loss_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
